// File: rtl/ber_counter.sv
// Dual-lane BER counter: aligns each received lane to the PRBS reference by exhaustive delay search, then counts bits/errors.
// Build option: define BER_SATURATE_EN to make the bit/error counters saturate instead of wrapping.

module ber_lane #(
    parameter int REF_DEPTH     = 511,
    parameter int SYNC_WINDOW   = 511,
    parameter int LOG_COUNT_LEN = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     valid,
    input  logic                     ref_bit,
    input  logic                     rx_bit,
    output logic [LOG_COUNT_LEN-1:0] bit_count,
    output logic [LOG_COUNT_LEN-1:0] error_count,
    output logic                     synced
);

    localparam int DW = (REF_DEPTH > 1) ? $clog2(REF_DEPTH) : 1;
    localparam int WW = $clog2(SYNC_WINDOW + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        COUNT  = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [REF_DEPTH-2:0]     line_r;
    logic [REF_DEPTH-1:0]     taps_s;
    logic                     cmp_s;
    logic [DW-1:0]            delay_r;
    logic [DW-1:0]            best_r;
    logic [WW-1:0]            win_cnt_r;
    logic [WW-1:0]            win_err_r;
    logic [WW-1:0]            min_err_r;
    logic [WW-1:0]            win_err_next_s;
    logic                     win_done_s;
    logic                     last_delay_s;
    logic                     better_s;
    logic [LOG_COUNT_LEN-1:0] bit_cnt_r;
    logic [LOG_COUNT_LEN-1:0] err_cnt_r;
    logic                     synced_r;

    // Window error accumulator never wraps, so a hopeless window cannot look like a good one.
    function automatic logic [WW-1:0] win_add(input logic [WW-1:0] acc, input logic inc);
        if (inc && (acc != {WW{1'b1}})) begin
            return acc + WW'(1);
        end else begin
            return acc;
        end
    endfunction

    function automatic logic [LOG_COUNT_LEN-1:0] cnt_add(input logic [LOG_COUNT_LEN-1:0] acc,
                                                         input logic inc);
`ifdef BER_SATURATE_EN
        if (inc && (acc != {LOG_COUNT_LEN{1'b1}})) begin
            return acc + LOG_COUNT_LEN'(1);
        end else begin
            return acc;
        end
`else
        return acc + LOG_COUNT_LEN'(inc);
`endif
    endfunction

    // Tap 0 is the reference bit arriving with the current strobe.
    always_comb begin
        taps_s         = {line_r, ref_bit};
        cmp_s          = taps_s[delay_r] ^ rx_bit;
        win_err_next_s = win_add(win_err_r, cmp_s);
        win_done_s     = (win_cnt_r == WW'(SYNC_WINDOW - 1));
        last_delay_s   = (delay_r == DW'(REF_DEPTH - 1));
        better_s       = (win_err_next_s < min_err_r);
    end

    // Next-state selection; dropping enable always returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_next_s = SEARCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEARCH: begin
                if (!enable) begin
                    state_next_s = IDLE;
                end else if (valid && win_done_s && last_delay_s) begin
                    state_next_s = COUNT;
                end else begin
                    state_next_s = SEARCH;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = COUNT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Delay line, search bookkeeping and output counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_r    <= '0;
            delay_r   <= '0;
            best_r    <= '0;
            win_cnt_r <= '0;
            win_err_r <= '0;
            min_err_r <= '0;
            bit_cnt_r <= '0;
            err_cnt_r <= '0;
            synced_r  <= 1'b0;
        end else begin
            if (valid) begin
                line_r <= taps_s[REF_DEPTH-2:0];
            end
            case (state_r)
                IDLE: begin
                    if (enable) begin
                        delay_r   <= '0;
                        best_r    <= '0;
                        win_cnt_r <= '0;
                        win_err_r <= '0;
                        min_err_r <= {WW{1'b1}};
                        bit_cnt_r <= '0;
                        err_cnt_r <= '0;
                        synced_r  <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (enable && valid) begin
                        if (win_done_s) begin
                            win_cnt_r <= '0;
                            win_err_r <= '0;
                            // Strict less-than: on a tie the earlier (smaller) delay is kept.
                            if (better_s) begin
                                min_err_r <= win_err_next_s;
                                best_r    <= delay_r;
                            end
                            if (last_delay_s) begin
                                delay_r  <= better_s ? delay_r : best_r;
                                synced_r <= 1'b1;
                            end else begin
                                delay_r <= delay_r + DW'(1);
                            end
                        end else begin
                            win_cnt_r <= win_cnt_r + WW'(1);
                            win_err_r <= win_err_next_s;
                        end
                    end
                end
                COUNT: begin
                    if (enable && valid) begin
                        bit_cnt_r <= cnt_add(bit_cnt_r, 1'b1);
                        err_cnt_r <= cnt_add(err_cnt_r, cmp_s);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bit_count   = bit_cnt_r;
    assign error_count = err_cnt_r;
    assign synced      = synced_r;

endmodule

module ber_counter #(
    parameter int REF_DEPTH     = 511,
    parameter int SYNC_WINDOW   = 511,
    parameter int LOG_COUNT_LEN = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     valid,
    input  logic                     ref_r,
    input  logic                     ref_i,
    input  logic                     rx_r,
    input  logic                     rx_i,
    output logic [LOG_COUNT_LEN-1:0] bit_count_r,
    output logic [LOG_COUNT_LEN-1:0] bit_count_i,
    output logic [LOG_COUNT_LEN-1:0] error_count_r,
    output logic [LOG_COUNT_LEN-1:0] error_count_i,
    output logic                     synced_r,
    output logic                     synced_i
);

    ber_lane #(
        .REF_DEPTH    (REF_DEPTH),
        .SYNC_WINDOW  (SYNC_WINDOW),
        .LOG_COUNT_LEN(LOG_COUNT_LEN)
    ) u_lane_r (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .valid      (valid),
        .ref_bit    (ref_r),
        .rx_bit     (rx_r),
        .bit_count  (bit_count_r),
        .error_count(error_count_r),
        .synced     (synced_r)
    );

    ber_lane #(
        .REF_DEPTH    (REF_DEPTH),
        .SYNC_WINDOW  (SYNC_WINDOW),
        .LOG_COUNT_LEN(LOG_COUNT_LEN)
    ) u_lane_i (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .valid      (valid),
        .ref_bit    (ref_i),
        .rx_bit     (rx_i),
        .bit_count  (bit_count_i),
        .error_count(error_count_i),
        .synced     (synced_i)
    );

endmodule

// File: tb/tb_ber_counter.sv
// Scoreboard bench for ber_counter: a behavioural lane model pushes expected outputs per cycle, popped after each clock edge.

module tb_ber_counter;

    localparam int REF_DEPTH     = 16;
    localparam int SYNC_WINDOW   = 32;
    localparam int LOG_COUNT_LEN = 64;
    localparam int SEARCH_LEN    = REF_DEPTH * SYNC_WINDOW;

    typedef struct packed {
        logic [63:0] br;
        logic [63:0] er;
        logic [63:0] bi;
        logic [63:0] ei;
        logic        sr;
        logic        si;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic        ref_r = 1'b0;
    logic        ref_i = 1'b0;
    logic        rx_r = 1'b0;
    logic        rx_i = 1'b0;
    logic [63:0] bit_count_r;
    logic [63:0] bit_count_i;
    logic [63:0] error_count_r;
    logic [63:0] error_count_i;
    logic        synced_r;
    logic        synced_i;

    ber_counter #(
        .REF_DEPTH    (REF_DEPTH),
        .SYNC_WINDOW  (SYNC_WINDOW),
        .LOG_COUNT_LEN(LOG_COUNT_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .valid        (valid),
        .ref_r        (ref_r),
        .ref_i        (ref_i),
        .rx_r         (rx_r),
        .rx_i         (rx_i),
        .bit_count_r  (bit_count_r),
        .bit_count_i  (bit_count_i),
        .error_count_r(error_count_r),
        .error_count_i(error_count_i),
        .synced_r     (synced_r),
        .synced_i     (synced_i)
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          dly = 0;
    logic [31:0] hist = 32'd0;
    int          m_state = 0;
    int          m_scnt = 0;
    logic [63:0] m_br = 64'd0;
    logic [63:0] m_er = 64'd0;
    logic [63:0] m_bi = 64'd0;
    logic [63:0] m_ei = 64'd0;
    logic        m_sr = 1'b0;
    logic        m_si = 1'b0;

    function automatic logic [63:0] inc(input logic [63:0] x, input logic d);
`ifdef BER_SATURATE_EN
        if (d && (x != 64'hFFFF_FFFF_FFFF_FFFF)) return x + 64'd1;
        return x;
`else
        return x + {63'd0, d};
`endif
    endfunction

    function automatic exp_t obs();
        return {bit_count_r, error_count_r, bit_count_i, error_count_i, synced_r, synced_i};
    endfunction

    task automatic reset_model();
        m_state = 0; m_scnt = 0;
        m_br = 64'd0; m_er = 64'd0; m_bi = 64'd0; m_ei = 64'd0;
        m_sr = 1'b0; m_si = 1'b0;
    endtask

    // Drive one cycle from a negedge, advance the model, queue the expectation, return at the next negedge.
    task automatic drive(input logic en, input logic v, input logic flip);
        logic b;
        b = 1'($urandom_range(0, 1));
        enable = en;
        valid  = v;
        ref_r  = b;
        ref_i  = 1'b0;
        rx_i   = 1'b0;
        if (v) hist = {hist[30:0], b};
        rx_r = hist[dly] ^ flip;
        if (!en) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: begin
                    m_state = 1; m_scnt = 0;
                    m_br = 64'd0; m_er = 64'd0; m_bi = 64'd0; m_ei = 64'd0;
                    m_sr = 1'b0; m_si = 1'b0;
                end
                1: if (v) begin
                    m_scnt++;
                    if (m_scnt == SEARCH_LEN) begin
                        m_state = 2; m_sr = 1'b1; m_si = 1'b1;
                    end
                end
                default: if (v) begin
                    m_br = inc(m_br, 1'b1);
                    m_er = inc(m_er, flip);
                    m_bi = inc(m_bi, 1'b1);
                    m_ei = inc(m_ei, 1'b0);
                end
            endcase
        end
        sb_q.push_back({m_br, m_er, m_bi, m_ei, m_sr, m_si});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t got, exp;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL reset_values got=%h required=0", obs());
        end
        rst = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            drive(1'b0, 1'(k % 2), 1'b0);
            got = obs(); exp = sb_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL idle_cycle k=%0d got=%h required=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_lock();
        exp_t got, exp;
        int n;
        dly = 5;
        drive(1'b1, 1'b1, 1'b0);
        got = obs(); exp = sb_q.pop_front(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL lock_enable_edge got=%h required=%h", got, exp);
        end
        n = 0;
        for (int k = 0; k < 4 * SEARCH_LEN; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            n++;
            got = obs(); exp = sb_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL lock_search n=%0d got=%h required=%h", n, got, exp);
            end
            if (synced_r === 1'b1) break;
        end
        checks++;
        if (n !== SEARCH_LEN) begin
            failures++;
            $display("FAIL lock_latency got=%0d required=%0d", n, SEARCH_LEN);
        end
        for (int k = 0; k < 1000; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            got = obs(); exp = sb_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL lock_count k=%0d got=%h required=%h", k, got, exp);
            end
        end
        checks++;
        if (bit_count_r !== 64'd1000 || error_count_r !== 64'd0) begin
            failures++;
            $display("FAIL lock_totals got=%0d/%0d required=1000/0", bit_count_r, error_count_r);
        end
    endtask

    task automatic test_error_count();
        exp_t got, exp;
        for (int k = 1; k <= 1000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b1, 1'b0, 1'b0);
                got = obs(); exp = sb_q.pop_front(); checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL err_gap k=%0d got=%h required=%h", k, got, exp);
                end
            end
            drive(1'b1, 1'b1, 1'((k % 10) == 0));
            got = obs(); exp = sb_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL err_valid k=%0d got=%h required=%h", k, got, exp);
            end
        end
        checks++;
        if (bit_count_r !== 64'd2000 || error_count_r !== 64'd100 ||
            bit_count_i !== 64'd2000 || error_count_i !== 64'd0) begin
            failures++;
            $display("FAIL err_totals got=%0d/%0d/%0d/%0d required=2000/100/2000/0",
                     bit_count_r, error_count_r, bit_count_i, error_count_i);
        end
    endtask

    task automatic test_tie_lanes();
        exp_t got, exp;
        int n, n_r, n_i;
        drive(1'b0, 1'b1, 1'b0);
        got = obs(); exp = sb_q.pop_front(); checks++;
        if (got !== exp || bit_count_r !== 64'd2000) begin
            failures++;
            $display("FAIL disable_with_valid got=%h required=%h", got, exp);
        end
        dly = 9;
        drive(1'b1, 1'b1, 1'b0);
        got = obs(); exp = sb_q.pop_front(); checks++;
        if (got !== exp || got !== '0) begin
            failures++;
            $display("FAIL restart_clear got=%h required=%h", got, exp);
        end
        n = 0; n_r = 0; n_i = 0;
        for (int k = 0; k < 4 * SEARCH_LEN; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            n++;
            got = obs(); exp = sb_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL tie_search n=%0d got=%h required=%h", n, got, exp);
            end
            if (synced_r === 1'b1 && n_r == 0) n_r = n;
            if (synced_i === 1'b1 && n_i == 0) n_i = n;
            if (n_r != 0 && n_i != 0) break;
        end
        checks++;
        if (n_r !== SEARCH_LEN || n_i !== n_r) begin
            failures++;
            $display("FAIL tie_sync_latency got=%0d/%0d required=%0d/%0d", n_r, n_i, SEARCH_LEN, SEARCH_LEN);
        end
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            got = obs(); exp = sb_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL tie_count k=%0d got=%h required=%h", k, got, exp);
            end
        end
        checks++;
        if (dut.u_lane_r.delay_r !== 4'd9 || dut.u_lane_i.delay_r !== 4'd0) begin
            failures++;
            $display("FAIL tie_delays got=%0d/%0d required=9/0", dut.u_lane_r.delay_r, dut.u_lane_i.delay_r);
        end
        checks++;
        if (bit_count_r !== 64'd300 || error_count_r !== 64'd0 || error_count_i !== 64'd0) begin
            failures++;
            $display("FAIL tie_totals got=%0d/%0d/%0d required=300/0/0", bit_count_r, error_count_r, error_count_i);
        end
    endtask

    task automatic test_stop_restart();
        exp_t got, exp;
        for (int k = 0; k < 50; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            got = obs(); exp = sb_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL stop_hold k=%0d got=%h required=%h", k, got, exp);
            end
        end
        checks++;
        if (bit_count_r !== 64'd300 || synced_r !== 1'b1) begin
            failures++;
            $display("FAIL stop_final got=%0d/%0b required=300/1", bit_count_r, synced_r);
        end
        drive(1'b1, 1'b1, 1'b0);
        got = obs(); exp = sb_q.pop_front(); checks++;
        if (got !== exp || bit_count_r !== 64'd0 || synced_r !== 1'b0) begin
            failures++;
            $display("FAIL restart_zero got=%h required=%h", got, exp);
        end
        for (int k = 0; k < SEARCH_LEN + 5; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            got = obs(); exp = sb_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL restart_run k=%0d got=%h required=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t got, exp;
        logic [63:0] final_exp;
        dut.u_lane_r.bit_cnt_r = 64'hFFFF_FFFF_FFFF_FFFE;
        m_br = 64'hFFFF_FFFF_FFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            got = obs(); exp = sb_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL sat_step k=%0d got=%h required=%h", k, got, exp);
            end
        end
`ifdef BER_SATURATE_EN
        final_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        final_exp = 64'd1;
`endif
        checks++;
        if (bit_count_r !== final_exp) begin
            failures++;
            $display("FAIL sat_final got=%h required=%h", bit_count_r, final_exp);
        end
    endtask

    task automatic test_async_reset();
        exp_t got, exp;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            got = obs(); exp = sb_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL pre_reset k=%0d got=%h required=%h", k, got, exp);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h required=0", obs());
        end
        reset_model();
        hist = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            got = obs(); exp = sb_q.pop_front(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL post_reset k=%0d got=%h required=%h", k, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_error_count();
        test_tie_lanes();
        test_stop_restart();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
